// File: rtl/regs_file_mp_pkg.sv
// Shared widths, defaults and FSM encoding for the multi-read-port register file.
package regs_file_mp_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int CPU_WIDTH      = 32;

  localparam int DEF_DATA_W   = CPU_WIDTH;
  localparam int DEF_ADDR_W   = REG_ADDR_WIDTH;
  localparam int DEF_RD_PORTS = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACK   = 2'd2,
    ST_HOLD  = 2'd3
  } rf_state_e;

endpackage

// File: rtl/regs_file_rd_port.sv
// One combinational read port: clear/zero-register masking, write bypass, array mux.
module regs_file_rd_port
  import regs_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                               clearing,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               wr_valid,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]   mem,
  output logic [DATA_W-1:0]                  data
);

  // Masking beats bypass so entry 0 and the clear window always read zero.
  always_comb begin
    data = mem[addr];
    if (clearing || (ZERO_REG != 0 && addr == '0)) begin
      data = '0;
    end else if (BYPASS != 0 && wr_valid && wr_addr == addr) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/regs_file_mp.sv
// Multi-read-port register file with post-reset clear sequencer and
// req/ack JTAG debug access that yields to core writes.
module regs_file_mp
  import regs_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RD_PORTS = DEF_RD_PORTS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
  output logic                         init_busy_o,
  input  logic                         jtag_req_i,
  input  logic                         jtag_we_i,
  input  logic [ADDR_W-1:0]            jtag_addr_i,
  input  logic [DATA_W-1:0]            jtag_data_i,
  output logic                         jtag_ack_o,
  output logic [DATA_W-1:0]            jtag_data_o
);

  localparam int DEPTH = 2**ADDR_W;

  rf_state_e                     state;
  rf_state_e                     next_state;
  logic [ADDR_W-1:0]             clr_cnt;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic                          clearing;
  logic                          core_wr;
  logic                          jtag_go;
  logic                          jtag_wr;
  logic [DATA_W-1:0]             jtag_rd;

  assign clearing = (state == ST_CLEAR);
  assign core_wr  = !clearing && wr_en_i && !(ZERO_REG != 0 && wr_addr_i == '0);
  // A JTAG write colliding with any core write waits; reads never collide.
  assign jtag_go  = (state == ST_IDLE) && jtag_req_i && !(jtag_we_i && wr_en_i);
  assign jtag_wr  = jtag_go && jtag_we_i && !(ZERO_REG != 0 && jtag_addr_i == '0);

  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (&clr_cnt)    next_state = ST_IDLE;
      ST_IDLE:  if (jtag_go)     next_state = ST_ACK;
      ST_ACK:   next_state = jtag_req_i ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (!jtag_req_i) next_state = ST_IDLE;
      default:  next_state = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      init_busy_o <= 1'b1;
      jtag_ack_o  <= 1'b0;
      jtag_data_o <= '0;
    end else begin
      state       <= next_state;
      init_busy_o <= (next_state == ST_CLEAR);
      jtag_ack_o  <= (next_state == ST_ACK);
      if (clearing) clr_cnt <= clr_cnt + ADDR_W'(1);
      if (jtag_go && !jtag_we_i) jtag_data_o <= jtag_rd;
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (core_wr) mem[wr_addr_i]   <= wr_data_i;
        if (jtag_wr) mem[jtag_addr_i] <= jtag_data_i;
      end
    end
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    regs_file_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .clearing(clearing),
      .addr    (rd_addr_i[k*ADDR_W +: ADDR_W]),
      .wr_valid(core_wr),
      .wr_addr (wr_addr_i),
      .wr_data (wr_data_i),
      .mem     (mem),
      .data    (rd_data_o[k*DATA_W +: DATA_W])
    );
  end

  regs_file_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_jtag_rd (
    .clearing(clearing),
    .addr    (jtag_addr_i),
    .wr_valid(core_wr),
    .wr_addr (wr_addr_i),
    .wr_data (wr_data_i),
    .mem     (mem),
    .data    (jtag_rd)
  );

endmodule

// File: tb/tb_regs_file_mp.sv
// Randomised self-checking bench for regs_file_mp against an array-based reference model.
module tb_regs_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic        init_busy_o;
  logic        jtag_req_i;
  logic        jtag_we_i;
  logic [4:0]  jtag_addr_i;
  logic [31:0] jtag_data_i;
  logic        jtag_ack_o;
  logic [31:0] jtag_data_o;

  logic [31:0] model [32];
  int total = 0;
  int bad   = 0;

  regs_file_mp dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .init_busy_o(init_busy_o),
    .jtag_req_i (jtag_req_i),
    .jtag_we_i  (jtag_we_i),
    .jtag_addr_i(jtag_addr_i),
    .jtag_data_i(jtag_data_i),
    .jtag_ack_o (jtag_ack_o),
    .jtag_data_o(jtag_data_o)
  );

  always #5 clk = ~clk;

  // Architectural read value: x0 is zero, a live core write to the same address is forwarded.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic idle_inputs();
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
    jtag_req_i = 1'b0; jtag_we_i = 1'b0; jtag_addr_i = '0; jtag_data_i = '0;
  endtask

  task automatic jtag_wait_ack(output bit seen, output int cycles);
    seen = 1'b0; cycles = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk); @(negedge clk); #1;
      cycles = c + 1;
      if (jtag_ack_o) seen = 1'b1;
    end
  endtask

  task automatic clear_window(input string tag);
    bit in_clear;
    for (int i = 0; i < 40; i++) begin
      in_clear    = (i < 32);
      wr_en_i     = in_clear ? 1'($urandom % 2) : 1'b0;
      wr_addr_i   = 5'($urandom);
      wr_data_i   = $urandom;
      rd_addr_i   = 10'($urandom);
      jtag_req_i  = in_clear ? 1'($urandom % 2) : 1'b0;
      jtag_we_i   = 1'($urandom % 2);
      jtag_addr_i = 5'($urandom);
      jtag_data_i = $urandom;
      #1;
      total++;
      if (init_busy_o !== in_clear) begin
        bad++; $display("[TB] FAIL %s busy i=%0d got=%b exp=%b", tag, i, init_busy_o, in_clear);
      end
      total++;
      if (jtag_ack_o !== 1'b0) begin
        bad++; $display("[TB] FAIL %s ack_in_clear i=%0d got=%b exp=0", tag, i, jtag_ack_o);
      end
      if (in_clear) begin
        total++;
        if (rd_data_o !== 64'h0) begin
          bad++; $display("[TB] FAIL %s rd_zero i=%0d got=%h exp=0", tag, i, rd_data_o);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      model[a] = 32'h0;
      rd_addr_i = {5'(a), 5'(31 - a)};
      #1;
      total++;
      if (rd_data_o !== 64'h0) begin
        bad++; $display("[TB] FAIL %s swept a=%0d got=%h exp=0", tag, a, rd_data_o);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (jtag_data_o !== 32'h0 || jtag_ack_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_regs got ack=%b data=%h exp ack=0 data=0", jtag_ack_o, jtag_data_o);
    end
    rst = 1'b0;
    clear_window("reset");
  endtask

  task automatic test_bypass();
    wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEADBEEF;
    rd_addr_i = {5'd0, 5'd5};
    #1;
    total++;
    if (rd_data_o[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL bypass_p0 got=%h exp=deadbeef", rd_data_o[31:0]);
    end
    total++;
    if (rd_data_o[63:32] !== 32'h0) begin
      bad++; $display("[TB] FAIL bypass_p1 got=%h exp=0", rd_data_o[63:32]);
    end
    @(posedge clk); model[5] = 32'hDEADBEEF;
    @(negedge clk);
    wr_en_i = 1'b0;
    #1;
    total++;
    if (rd_data_o[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL array_p0 got=%h exp=deadbeef", rd_data_o[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    bit seen; int cyc;
    wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'h1234; rd_addr_i = 10'd0;
    #1;
    total++;
    if (rd_data_o !== 64'h0) begin
      bad++; $display("[TB] FAIL x0_same got=%h exp=0", rd_data_o);
    end
    @(posedge clk); @(negedge clk);
    wr_en_i = 1'b0;
    #1;
    total++;
    if (rd_data_o !== 64'h0) begin
      bad++; $display("[TB] FAIL x0_next got=%h exp=0", rd_data_o);
    end
    for (int k = 0; k < 2; k++) begin
      jtag_req_i = 1'b1; jtag_we_i = 1'b0; jtag_addr_i = (k == 0) ? 5'd5 : 5'd0;
      jtag_wait_ack(seen, cyc);
      total++;
      if (!seen || cyc != 1) begin
        bad++; $display("[TB] FAIL jtag_rd_lat k=%0d got=%0d exp=1", k, seen ? cyc : -1);
      end
      total++;
      if (jtag_data_o !== ((k == 0) ? model[5] : 32'h0)) begin
        bad++; $display("[TB] FAIL jtag_rd_data k=%0d got=%h exp=%h", k, jtag_data_o,
                        (k == 0) ? model[5] : 32'h0);
      end
      jtag_req_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_conflict();
    bit seen; int cyc;
    for (int c = 0; c < 8; c++) begin
      wr_en_i = (c < 3); wr_addr_i = 5'd9; wr_data_i = $urandom;
      jtag_req_i = (c < 4); jtag_we_i = 1'b1; jtag_addr_i = 5'd7; jtag_data_i = 32'hA5A5;
      #1;
      total++;
      if (jtag_ack_o !== (c == 4)) begin
        bad++; $display("[TB] FAIL conflict_ack c=%0d got=%b exp=%b", c, jtag_ack_o, (c == 4));
      end
      @(posedge clk);
      if (wr_en_i) model[9] = wr_data_i;
      if (c == 3) model[7] = 32'hA5A5;
      @(negedge clk);
    end
    idle_inputs();
    rd_addr_i = {5'd9, 5'd7};
    #1;
    total++;
    if (rd_data_o !== {model[9], 32'h0000A5A5}) begin
      bad++; $display("[TB] FAIL conflict_array got=%h exp=%h", rd_data_o, {model[9], 32'h0000A5A5});
    end
    jtag_req_i = 1'b1; jtag_we_i = 1'b0; jtag_addr_i = 5'd7;
    jtag_wait_ack(seen, cyc);
    total++;
    if (!seen || jtag_data_o !== 32'hA5A5) begin
      bad++; $display("[TB] FAIL conflict_jtag_rd got=%h seen=%b exp=0000a5a5", jtag_data_o, seen);
    end
    jtag_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [31:0] a_val, b_val;
    int acks; bit seen; int cyc;
    a_val = $urandom | 32'h1; b_val = ~a_val; acks = 0;
    for (int c = 0; c < 9; c++) begin
      jtag_req_i = (c < 7); jtag_we_i = 1'b1; jtag_addr_i = 5'd12;
      jtag_data_i = (c == 0) ? a_val : b_val;
      #1;
      if (jtag_ack_o) acks++;
      total++;
      if (jtag_ack_o !== (c == 1)) begin
        bad++; $display("[TB] FAIL hold_ack c=%0d got=%b exp=%b", c, jtag_ack_o, (c == 1));
      end
      @(negedge clk);
    end
    model[12] = a_val;
    total++;
    if (acks != 1) begin
      bad++; $display("[TB] FAIL hold_ack_count got=%0d exp=1", acks);
    end
    idle_inputs();
    rd_addr_i = {5'd0, 5'd12};
    #1;
    total++;
    if (rd_data_o[31:0] !== a_val) begin
      bad++; $display("[TB] FAIL hold_single_write got=%h exp=%h", rd_data_o[31:0], a_val);
    end
    jtag_req_i = 1'b1; jtag_we_i = 1'b0; jtag_addr_i = 5'd12;
    jtag_wait_ack(seen, cyc);
    total++;
    if (!seen || cyc != 1 || jtag_data_o !== a_val) begin
      bad++; $display("[TB] FAIL hold_release got lat=%0d data=%h exp lat=1 data=%h",
                      seen ? cyc : -1, jtag_data_o, a_val);
    end
    jtag_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_core();
    logic [4:0] a0, a1;
    logic [31:0] e0, e1;
    logic cw;
    for (int n = 0; n < 150; n++) begin
      wr_en_i = 1'($urandom % 2); wr_addr_i = 5'($urandom); wr_data_i = $urandom;
      a0 = ($urandom % 4 == 0) ? wr_addr_i : 5'($urandom);
      a1 = ($urandom % 4 == 0) ? wr_addr_i : 5'($urandom);
      rd_addr_i = {a1, a0};
      cw = wr_en_i && wr_addr_i != 5'd0;
      e0 = ref_read(a0, cw, wr_addr_i, wr_data_i);
      e1 = ref_read(a1, cw, wr_addr_i, wr_data_i);
      #1;
      total++;
      if (rd_data_o !== {e1, e0}) begin
        bad++; $display("[TB] FAIL rand_rd n=%0d a0=%0d a1=%0d got=%h exp=%h", n, a0, a1, rd_data_o, {e1, e0});
      end
      @(posedge clk);
      if (cw) model[wr_addr_i] = wr_data_i;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_random_jtag();
    logic [4:0] ja; logic jw; logic [31:0] jd, exp_d;
    logic cw; bit served, done;
    for (int n = 0; n < 24; n++) begin
      ja = 5'($urandom); jw = 1'($urandom % 2); jd = $urandom;
      served = 1'b0; done = 1'b0; exp_d = jtag_data_o;
      for (int c = 0; c < 16 && !done; c++) begin
        jtag_req_i = !served; jtag_we_i = jw; jtag_addr_i = ja; jtag_data_i = jd;
        wr_en_i = (c < 10) ? ($urandom % 3 == 0) : 1'b0;
        wr_addr_i = ($urandom % 2) ? ja : 5'($urandom); wr_data_i = $urandom;
        cw = wr_en_i && wr_addr_i != 5'd0;
        #1;
        total++;
        if (jtag_ack_o !== served) begin
          bad++; $display("[TB] FAIL rj_ack n=%0d c=%0d got=%b exp=%b", n, c, jtag_ack_o, served);
        end
        if (served) begin
          total++;
          if (jtag_data_o !== exp_d) begin
            bad++; $display("[TB] FAIL rj_data n=%0d we=%b a=%0d got=%h exp=%h", n, jw, ja, jtag_data_o, exp_d);
          end
          done = 1'b1;
          @(posedge clk);
          if (cw) model[wr_addr_i] = wr_data_i;
        end else if (!(jw && wr_en_i)) begin
          if (!jw) exp_d = ref_read(ja, cw, wr_addr_i, wr_data_i);
          @(posedge clk);
          if (cw) model[wr_addr_i] = wr_data_i;
          if (jw && ja != 5'd0) model[ja] = jd;
          served = 1'b1;
        end else begin
          @(posedge clk);
          if (cw) model[wr_addr_i] = wr_data_i;
        end
        @(negedge clk);
      end
      total++;
      if (!done) begin
        bad++; $display("[TB] FAIL rj_timeout n=%0d got=no_ack exp=ack", n);
      end
    end
    idle_inputs();
    for (int a = 0; a < 32; a += 2) begin
      rd_addr_i = {5'(a + 1), 5'(a)};
      #1;
      total++;
      if (rd_data_o !== {model[a+1], (a == 0) ? 32'h0 : model[a]}) begin
        bad++; $display("[TB] FAIL rj_array a=%0d got=%h exp=%h", a, rd_data_o,
                        {model[a+1], (a == 0) ? 32'h0 : model[a]});
      end
    end
  endtask

  task automatic test_reset_mid_ack();
    wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hCAFEF00D;
    @(posedge clk); model[5] = 32'hCAFEF00D;
    @(negedge clk);
    wr_en_i = 1'b0;
    jtag_req_i = 1'b1; jtag_we_i = 1'b0; jtag_addr_i = 5'd5;
    @(posedge clk); @(negedge clk);
    #1;
    total++;
    if (jtag_ack_o !== 1'b1 || jtag_data_o !== 32'hCAFEF00D) begin
      bad++; $display("[TB] FAIL pre_reset_ack got ack=%b data=%h exp ack=1 data=cafef00d", jtag_ack_o, jtag_data_o);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    total++;
    if (jtag_ack_o !== 1'b0 || jtag_data_o !== 32'h0 || init_busy_o !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_ack_reset got ack=%b data=%h busy=%b exp ack=0 data=0 busy=1",
                      jtag_ack_o, jtag_data_o, init_busy_o);
    end
    rst = 1'b0;
    jtag_req_i = 1'b0;
    clear_window("reclear");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    for (int a = 0; a < 32; a++) model[a] = 32'h0;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_zero_reg();
    test_conflict();
    test_hold();
    test_random_core();
    test_random_jtag();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
